fb_write_scheduler: RTL and testbench

Shares the single 64×64 framebuffer write port between NUM_REQ pixel-write requesters (pattern generator, physics renderer, debug overlay) with round-robin arbitration. It also contains a screen-clear sequencer that takes the port exclusively for one full raster of CLEAR_COLOR writes. It sits between the pixel producers and the framebuffer RAM write side and drives the same write_en/write_x/write_y/pixel_color bundle the RAM already consumes.

---
 rtl/fb_write_scheduler_pkg.sv | 19 +
 rtl/fb_write_scheduler_if.sv | 32 +++
 rtl/fb_write_scheduler_rr_arbiter.sv | 29 ++
 rtl/fb_write_scheduler.sv | 95 +++++++++
 tb/tb_fb_write_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_scheduler_pkg.sv
// rtl/fb_write_scheduler_pkg.sv - shared framebuffer geometry, pixel write record and scheduler states
package fb_pkg;
   localparam int FB_W    = 64;
   localparam int FB_H    = 64;
   localparam int COORD_W = 6;
   localparam int COLOR_W = 12;
   localparam int CNT_W   = 2 * COORD_W;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COLOR_W-1:0] color;
   } pixel_write_t;

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } sched_state_t;
endpackage

// File: rtl/fb_write_scheduler_if.sv
// rtl/fb_write_scheduler_if.sv - requester, clear-control and framebuffer write bundle
interface fb_write_scheduler_if #(
   parameter int NUM_REQ = 3
);
   import fb_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0][COORD_W-1:0] req_x;
   logic [NUM_REQ-1:0][COORD_W-1:0] req_y;
   logic [NUM_REQ-1:0][COLOR_W-1:0] req_color;
   logic                            clear_start;
   logic                            clear_busy;
   logic                            clear_done;
   logic                            write_en;
   logic [COORD_W-1:0]              write_x;
   logic [COORD_W-1:0]              write_y;
   logic [COLOR_W-1:0]              pixel_color;
   logic [ID_W-1:0]                 grant_id;

   modport master (
      output req_valid, req_x, req_y, req_color, clear_start,
      input  req_ready, clear_busy, clear_done, write_en, write_x, write_y, pixel_color, grant_id
   );

   modport slave (
      input  req_valid, req_x, req_y, req_color, clear_start,
      output req_ready, clear_busy, clear_done, write_en, write_x, write_y, pixel_color, grant_id
   );
endinterface

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// rtl/fb_write_scheduler_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
   parameter int N    = 3,
   parameter int ID_W = $clog2(N)
) (
   input  logic            en,
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_valid
);
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt       = '0;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      idx       = '0;
      for (int i = 1; i <= N; i++) begin
         idx = ID_W'((int'(last) + i) % N);
         if (en && !gnt_valid && req[idx]) begin
            gnt[idx]  = 1'b1;
            gnt_id    = idx;
            gnt_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - round-robin framebuffer write port sharing with a full-raster clear sequencer
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int                 NUM_REQ     = 3,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR = 12'h000
) (
   input logic                 clk,
   input logic                 rst_n,
   fb_write_scheduler_if.slave bus
);
   localparam int              ID_W     = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB_W * FB_H - 1);

   sched_state_t       state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [ID_W-1:0]    last;
   logic [ID_W-1:0]    gnt_id;
   logic [ID_W-1:0]    gid_q;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_valid;
   logic               arb_en;
   logic               wr_en_q;
   logic               done_q;
   pixel_write_t       wr_q;

   // ready is gated by reset so nothing is accepted while the port is held in reset
   assign arb_en = rst_n && (state == ARB) && !bus.clear_start;

   rr_arbiter #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .en        (arb_en),
      .req       (bus.req_valid),
      .last      (last),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ARB:     if (bus.clear_start) state_nxt = CLEAR;
         CLEAR:   if (cnt == CNT_LAST) state_nxt = ARB;
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ARB;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         last    <= ID_W'(NUM_REQ - 1);
         wr_en_q <= 1'b0;
         wr_q    <= '0;
         gid_q   <= '0;
         done_q  <= 1'b0;
      end else if (state == CLEAR) begin
         wr_en_q <= 1'b1;
         wr_q    <= '{x: cnt[COORD_W-1:0], y: cnt[CNT_W-1:COORD_W], color: CLEAR_COLOR};
         gid_q   <= '0;
         cnt     <= cnt + 1'b1;
         done_q  <= (cnt == CNT_LAST);
      end else begin
         done_q <= 1'b0;
         if (bus.clear_start) begin
            cnt     <= '0;
            wr_en_q <= 1'b0;
         end else if (gnt_valid) begin
            last    <= gnt_id;
            wr_en_q <= 1'b1;
            wr_q    <= '{x: bus.req_x[gnt_id], y: bus.req_y[gnt_id], color: bus.req_color[gnt_id]};
            gid_q   <= gnt_id;
         end else begin
            wr_en_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready   = gnt;
   assign bus.write_en    = wr_en_q;
   assign bus.write_x     = wr_q.x;
   assign bus.write_y     = wr_q.y;
   assign bus.pixel_color = wr_q.color;
   assign bus.grant_id    = gid_q;
   assign bus.clear_done  = done_q;
   // busy also covers the cycle showing the final clear write, which is already back in ARB
   assign bus.clear_busy  = (state == CLEAR) || done_q;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - randomized bench for fb_write_scheduler against a cycle-arithmetic model
module tb_fb_write_scheduler;
   import fb_pkg::*;

   localparam int          N  = 3;
   localparam logic [11:0] CC = 12'h000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fb_write_scheduler_if #(.NUM_REQ(N)) bus ();

   fb_write_scheduler #(
      .NUM_REQ     (N),
      .CLEAR_COLOR (CC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int          clear_s;
   int          last_m;
   logic        exp_we, exp_done, exp_busy;
   logic [5:0]  exp_x, exp_y;
   logic [11:0] exp_col;
   logic [1:0]  exp_gid;
   logic [2:0]  exp_ready;
   logic [2:0]  smp_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      clear_s  = -1;
      last_m   = N - 1;
      exp_we   = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_x    = '0;
      exp_y    = '0;
      exp_col  = '0;
      exp_gid  = '0;
   endtask

   task automatic rand_data();
      for (int k = 0; k < N; k++) begin
         bus.req_x[k]     = 6'($urandom_range(0, 63));
         bus.req_y[k]     = 6'($urandom_range(0, 63));
         bus.req_color[k] = 12'($urandom_range(0, 4095));
      end
   endtask

   // One cycle: inputs already driven at the preceding negedge; ends at the next negedge.
   task automatic tick();
      int  win;
      int  idx;
      bit  blocked;
      #1;
      blocked   = (clear_s >= 0) && (cyc >= clear_s + 1) && (cyc <= clear_s + 4096);
      exp_ready = '0;
      win       = -1;
      if (!blocked && !bus.clear_start) begin
         for (int i = 1; i <= N; i++) begin
            if (win < 0 && bus.req_valid[(last_m + i) % N]) win = (last_m + i) % N;
         end
      end
      if (win >= 0) exp_ready = 3'(1 << win);
      if (clear_s >= 0 && cyc + 1 >= clear_s + 2 && cyc + 1 <= clear_s + 4097) begin
         idx      = cyc + 1 - clear_s - 2;
         exp_we   = 1'b1;
         exp_x    = 6'(idx % 64);
         exp_y    = 6'(idx / 64);
         exp_col  = CC;
         exp_gid  = '0;
         exp_done = (cyc + 1 == clear_s + 4097);
      end else if (win >= 0) begin
         exp_we   = 1'b1;
         exp_x    = bus.req_x[win];
         exp_y    = bus.req_y[win];
         exp_col  = bus.req_color[win];
         exp_gid  = 2'(win);
         exp_done = 1'b0;
         last_m   = win;
      end else begin
         exp_we   = 1'b0;
         exp_done = 1'b0;
      end
      if (!blocked && bus.clear_start) clear_s = cyc;
      exp_busy  = (clear_s >= 0) && (cyc + 1 >= clear_s + 1) && (cyc + 1 <= clear_s + 4097);
      smp_ready = bus.req_ready;
      chk("req_ready", bus.req_ready, exp_ready);
      @(negedge clk);
      cyc++;
      chk("write_en", bus.write_en, exp_we);
      chk("write_x", bus.write_x, exp_x);
      chk("write_y", bus.write_y, exp_y);
      chk("pixel_color", bus.pixel_color, exp_col);
      chk("grant_id", bus.grant_id, exp_gid);
      chk("clear_busy", bus.clear_busy, exp_busy);
      chk("clear_done", bus.clear_done, exp_done);
   endtask

   // Called at a negedge; drops reset between clock edges to show the asynchronous clear of outputs.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      bus.clear_start = 1'b0;
      #1;
      chk("rst_write_en", bus.write_en, 0);
      chk("rst_write_x", bus.write_x, 0);
      chk("rst_write_y", bus.write_y, 0);
      chk("rst_color", bus.pixel_color, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      chk("rst_busy", bus.clear_busy, 0);
      chk("rst_done", bus.clear_done, 0);
      chk("rst_ready", bus.req_ready, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int nclr, ndone, done_at, nbusy_ready;
      bus.req_valid   = '0;
      bus.clear_start = 1'b0;
      rand_data();
      model_reset();
      @(negedge clk);
      do_reset();

      // single requester 1
      bus.req_valid    = 3'b010;
      bus.req_x[1]     = 6'd5;
      bus.req_y[1]     = 6'd7;
      bus.req_color[1] = 12'hABC;
      tick();
      chk("a_ready", smp_ready, 3'b010);
      chk("a_we", bus.write_en, 1);
      chk("a_x", bus.write_x, 5);
      chk("a_y", bus.write_y, 7);
      chk("a_color", bus.pixel_color, 12'hABC);
      chk("a_gid", bus.grant_id, 1);

      // idle: outputs hold
      bus.req_valid = '0;
      for (int i = 0; i < 10; i++) begin
         rand_data();
         tick();
         chk("idle_we", bus.write_en, 0);
         chk("idle_hold", {bus.write_x, bus.write_y, bus.pixel_color}, {6'd5, 6'd7, 12'hABC});
      end

      // round robin from reset
      do_reset();
      bus.req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         rand_data();
         tick();
         chk("rr_gid", bus.grant_id, i % 3);
         chk("rr_we", bus.write_en, 1);
      end

      // clear with simultaneous req 0, second clear_start ignored
      bus.req_valid    = 3'b001;
      bus.req_x[0]     = 6'd1;
      bus.req_y[0]     = 6'd2;
      bus.req_color[0] = 12'h123;
      bus.clear_start  = 1'b1;
      tick();
      chk("c_ready_n", smp_ready, 0);
      nclr = 0; ndone = 0; done_at = -1; nbusy_ready = 0;
      for (int i = 1; i <= 4097; i++) begin
         bus.clear_start = (i == 100);
         tick();
         if (i <= 4096) begin
            if (smp_ready != 0) nbusy_ready++;
            if (bus.write_en && bus.pixel_color == CC) nclr++;
            if (bus.clear_done) begin
               ndone++;
               done_at = i;
            end
         end
      end
      chk("c_ready_zero", nbusy_ready, 0);
      chk("c_writes", nclr, 4096);
      chk("c_done_cnt", ndone, 1);
      chk("c_done_at", done_at, 4096);
      chk("c_ready_after", smp_ready, 3'b001);
      chk("c_post_we", bus.write_en, 1);
      chk("c_post_xy", {bus.write_x, bus.write_y}, {6'd1, 6'd2});
      chk("c_post_color", bus.pixel_color, 12'h123);
      chk("c_post_gid", bus.grant_id, 0);
      bus.req_valid = '0;

      // reset in the middle of a clear
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      for (int i = 1; i < 2000; i++) tick();
      do_reset();
      bus.req_valid = 3'b111;
      rand_data();
      tick();
      chk("r_first_ready", smp_ready, 3'b001);
      ndone = 0;
      for (int i = 0; i < 4200; i++) begin
         bus.req_valid = 3'($urandom_range(0, 7));
         rand_data();
         tick();
         if (bus.clear_done) ndone++;
      end
      chk("r_no_done", ndone, 0);

      // random traffic with occasional clears
      for (int i = 0; i < 6000; i++) begin
         bus.req_valid   = 3'($urandom_range(0, 7));
         bus.clear_start = ($urandom_range(0, 2999) == 0);
         rand_data();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
